// File: rtl/bcd_seq_converter_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Digit width, default sizing and the controller state encoding live here.
package bcd_seq_converter_pkg;
  localparam int DEF_W       = 10;
  localparam int DEF_MAX_VAL = 999;
  localparam int BCD_W       = 4;
  localparam int NUM_DIG     = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/bcd_seq_converter_if.sv
// Request/result bundle between the reaction timer and the BCD converter.
// The timer side drives start/bin; the converter returns status and digits.
interface bcd_seq_converter_if
  import bcd_seq_converter_pkg::*;
#(
  parameter int W = DEF_W
);
  logic             start;
  logic [W-1:0]     bin;
  logic             busy;
  logic             done;
  logic             ovf;
  logic [BCD_W-1:0] hundreds;
  logic [BCD_W-1:0] tens;
  logic [BCD_W-1:0] ones;

  modport master (
    output start, bin,
    input  busy, done, ovf, hundreds, tens, ones
  );

  modport slave (
    input  start, bin,
    output busy, done, ovf, hundreds, tens, ones
  );
endinterface

// File: rtl/bcd_seq_converter_add3.sv
// Single-nibble double-dabble correction: add 3 when the digit is 5 or more.
// The result stays within the nibble; no carry leaves it.
module bcd_add3
  import bcd_seq_converter_pkg::*;
(
  input  logic [BCD_W-1:0] in_nib,
  output logic [BCD_W-1:0] out_nib
);
  always_comb begin
    out_nib = in_nib;
    if (in_nib >= BCD_W'(5)) out_nib = in_nib + BCD_W'(3);
  end
endmodule

// File: rtl/bcd_seq_converter.sv
// Iterative shift-add-3 binary-to-BCD converter with start/busy/done handshake.
// Inputs above MAX_VAL saturate to MAX_VAL and raise ovf for that result.
module bcd_seq_converter
  import bcd_seq_converter_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int MAX_VAL = DEF_MAX_VAL
) (
  input  logic               clk,
  input  logic               key0,
  bcd_seq_converter_if.slave io
);
  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam int SCR_W = NUM_DIG * BCD_W;

  state_e                           state_q, state_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic [NUM_DIG-1:0][BCD_W-1:0]    scr_q, scr_d;
  logic [W-1:0]                     sh_q, sh_d;
  logic                             ovf_nxt_q, ovf_nxt_d;
  logic [NUM_DIG-1:0][BCD_W-1:0]    dig_q, dig_d;
  logic                             ovf_q, ovf_d;
  logic                             done_q, done_d;

  logic [NUM_DIG-1:0][BCD_W-1:0]    adj;
  logic [SCR_W+W-1:0]               shifted;

  // One corrector per digit, applied before every shift.
  for (genvar g = 0; g < NUM_DIG; g++) begin : g_dig
    bcd_add3 u_add3 (
      .in_nib  (scr_q[g]),
      .out_nib (adj[g])
    );
  end

  assign shifted = {adj, sh_q} << 1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    scr_d     = scr_q;
    sh_d      = sh_q;
    ovf_nxt_d = ovf_nxt_q;
    dig_d     = dig_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (io.start) begin
          if (int'(io.bin) > MAX_VAL) begin
            sh_d      = W'(MAX_VAL);
            ovf_nxt_d = 1'b1;
          end else begin
            sh_d      = io.bin;
            ovf_nxt_d = 1'b0;
          end
          scr_d   = '0;
          cnt_d   = '0;
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        scr_d = shifted[SCR_W+W-1 -: SCR_W];
        sh_d  = shifted[W-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(W-1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        // Digits and ovf only move here, so partial results never leak out.
        dig_d   = scr_q;
        ovf_d   = ovf_nxt_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge key0) begin
    if (!key0) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      scr_q     <= '0;
      sh_q      <= '0;
      ovf_nxt_q <= 1'b0;
      dig_q     <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      scr_q     <= scr_d;
      sh_q      <= sh_d;
      ovf_nxt_q <= ovf_nxt_d;
      dig_q     <= dig_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign io.busy     = (state_q != ST_IDLE);
  assign io.done     = done_q;
  assign io.ovf      = ovf_q;
  assign io.hundreds = dig_q[2];
  assign io.tens     = dig_q[1];
  assign io.ones     = dig_q[0];
endmodule

// File: tb/tb_bcd_seq_converter.sv
// Scoreboard bench: stimulus queues expected digits/ovf/done-cycle, a monitor
// pops and checks on every done pulse.
module tb_bcd_seq_converter;
  logic clk = 1'b0;
  logic key0 = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  typedef struct {
    int h; int t; int o; int ov; int at;
  } exp_t;
  exp_t sb[$];

  bcd_seq_converter_if #(.W(10)) bus ();

  bcd_seq_converter #(.W(10), .MAX_VAL(999)) dut (
    .clk  (clk),
    .key0 (key0),
    .io   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (key0 && bus.done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("hundreds", int'(bus.hundreds), e.h);
        chk("tens", int'(bus.tens), e.t);
        chk("ones", int'(bus.ones), e.o);
        chk("ovf", int'(bus.ovf), e.ov);
        chk("done_cycle", cyc, e.at);
      end
    end
  end

  task automatic issue(input int b, input int h, input int t, input int o, input int ov);
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 10'(b);
    @(posedge clk);
    #1;
    e.h = h; e.t = t; e.o = o; e.ov = ov; e.at = cyc + 11;
    sb.push_back(e);
    chk("busy_after_accept", int'(bus.busy), 1);
    @(negedge clk);
    bus.start = 1'b0;
    bus.bin   = 10'h3A5;  // scramble after acceptance; must not matter
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.busy) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("wait_idle_timeout", 1, 0);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    bus.start = 1'b0;
    bus.bin   = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_ovf", int'(bus.ovf), 0);
    chk("rst_digits", int'({bus.hundreds, bus.tens, bus.ones}), 0);
    key0 = 1'b1;
    @(negedge clk);

    issue(0, 0, 0, 0, 0);       wait_idle();
    chk("idle_busy", int'(bus.busy), 0);
    issue(255, 2, 5, 5, 0);     wait_idle();
    issue(999, 9, 9, 9, 0);     wait_idle();
    issue(1023, 9, 9, 9, 1);    wait_idle();
    issue(7, 0, 0, 7, 0);       wait_idle();
    issue(1000, 9, 9, 9, 1);    wait_idle();
    issue(998, 9, 9, 8, 0);     wait_idle();

    // Second request while busy must be dropped.
    issue(123, 1, 2, 3, 0);
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.bin = 10'd456;
    @(negedge clk);
    chk("busy_during_ignored", int'(bus.busy), 1);
    bus.start = 1'b0;
    wait_idle();
    repeat (15) @(negedge clk);
    chk("held_after_ignore", int'({bus.hundreds, bus.tens, bus.ones}), 12'h123);

    // Reset mid-conversion: abort, no done.
    @(negedge clk);
    bus.start = 1'b1; bus.bin = 10'd860;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 key0 = 1'b0;
    #1;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_digits", int'({bus.hundreds, bus.tens, bus.ones}), 0);
    chk("abort_done", int'(bus.done), 0);
    repeat (2) @(negedge clk);
    key0 = 1'b1;
    repeat (15) @(negedge clk);
    chk("abort_no_result", int'({bus.hundreds, bus.tens, bus.ones}), 0);
    issue(42, 0, 4, 2, 0);      wait_idle();

    // Start held high: a conversion every 12 cycles, digits steady.
    @(negedge clk);
    bus.start = 1'b1; bus.bin = 10'd100;
    @(posedge clk);
    #1;
    n0 = cyc;
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      e.h = 1; e.t = 0; e.o = 0; e.ov = 0; e.at = n0 + 11 + 12 * k;
      sb.push_back(e);
    end
    while (cyc < n0 + 24) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < n0 + 37) begin
      @(negedge clk);
      if (cyc >= n0 + 11)
        chk("held_stable", int'({bus.hundreds, bus.tens, bus.ones}), 12'h100);
    end
    wait_idle();
    repeat (14) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bcd_seq_converter.md
Name: bcd_seq_converter

Overview:
- Sequential binary-to-BCD converter (shift-add-3 / double-dabble) for the 0.01 s reaction-time count produced by the reaction timer.
- Sits between the timer's elapsed-count register and the three 7-segment digit decoders (hundreds/tens/ones).
- Replaces the combinational divide/modulo digit split with a W-cycle iterative converter using a start/busy/done handshake.
- Saturates at 999 and flags overflow.

Parameters:
- W, 10, width of the binary input in bits (10 bits covers 0..1023).
- MAX_VAL, 999, saturation value; largest count the three digits can show.

Ports:
- clk  input  1  system clock (50 MHz board clock)
- key0  input  1  asynchronous active-low reset (KEY0 push-button)
- start  input  1  single-cycle request to convert bin
- bin  input  W  binary count to convert, sampled only when start is accepted
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when the digit outputs update
- ovf  output  1  high when the last accepted bin exceeded MAX_VAL; held until the next accept
- hundreds  output  4  BCD hundreds digit, held between conversions
- tens  output  4  BCD tens digit, held
- ones  output  4  BCD ones digit, held

Behaviour:
- Reset (key0=0, asynchronous):
  - state=IDLE.
  - busy=0, done=0, ovf=0, hundreds=tens=ones=0.
  - Iteration counter and scratch registers cleared.
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - busy=0.
  - On start=1 at rising edge N, accept the request: if bin>MAX_VAL, latch MAX_VAL and set ovf_next=1; else latch bin and set ovf_next=0.
  - Clear the 12-bit BCD scratch register and set the iteration counter to 0. Go to CONV.
- CONV:
  - busy=1.
  - Each edge, in order: for each scratch nibble >=5, add 3 to it; then shift {scratch, binary shift register} left by 1, moving the binary MSB into scratch bit 0; then increment the counter.
  - After the W-th shift (counter reaches W-1 at that edge), go to DONE. Total: W edges, N+1..N+W.
- DONE:
  - busy=1 during this state.
  - At edge N+W+1: copy scratch into hundreds/tens/ones, copy ovf_next into ovf, pulse done=1 for exactly one cycle, return to IDLE.
- Latency: done is visible in the cycle after edge N+W+1 (11 edges for W=10). A new start is accepted on the next edge after done asserts.
- start while busy=1 (CONV or DONE) is ignored; it is not queued, and the in-flight conversion is unaffected.
- bin changes after acceptance have no effect; the input is latched.
- Outputs hundreds/tens/ones/ovf change only at the DONE edge or on reset; they never show partial results.
- Each nibble stays <=9 at every step. The add-3 correction is 4-bit with no carry-out between nibbles.
- Reset asserted mid-conversion: abort immediately, all outputs return to reset values, no done pulse.
- Back-to-back: if start is held high continuously, a conversion runs every W+2 cycles.

Decomposition:
- Shared package holds: state encoding (IDLE/CONV/DONE, 2-bit), default W, MAX_VAL=999, and the BCD digit width constant (4).
- One sub-module, bcd_add3: a combinational 4-bit nibble corrector (in>=5 ? in+3 : in). It is instantiated three times inside the shift datapath.
- FSM, counter, saturation and output registers stay in bcd_seq_converter.

Test Plan:
- Reset release, then start with bin=0 → done after 11 edges; digits 0,0,0; ovf=0; busy high for edges 1..11 inclusive of DONE.
- bin=255, start for one cycle → done pulse exactly 11 edges after start sampling; digits 2,5,5; ovf=0.
- bin=999 → 9,9,9, ovf=0. Then bin=1023 → 9,9,9, ovf=1. Then bin=7 → 0,0,7 and ovf returns to 0.
- Start bin=123; while busy, pulse start with bin=456 → only one done pulse; digits 1,2,3; the second request is ignored.
- Start bin=860; assert key0=0 at edge 5 → outputs 0,0,0 immediately, no done; after release, bin=42 converts to 0,4,2.
- Start held high with bin=100 → done pulses every 12 cycles; digits 1,0,0 stable, no glitches between pulses.
